// File: rtl/spinner_accum.sv
// Rotary position accumulator for IPA1J2: merges HPS spinner deltas and timed
// digital left/right steps into one modulo-256 position word.
module spinner_accum #(
    parameter int unsigned STEP_DIV    = 25000,
    parameter int unsigned DIG_STEP    = 2,
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [8:0] spinner_in,
    input  logic       dig_left,
    input  logic       dig_right,
    input  logic       enable,
    input  logic       invert,
    output logic [7:0] position,
    output logic       moved,
    output logic       direction
);

    localparam int unsigned CNT_W = $clog2(STEP_DIV + 1);
    localparam int unsigned SUM_W = 10;

    logic [8:0]       spin_q;
    logic             dl_q;
    logic             dr_q;
    logic             tog_prev;
    logic             primed;
    logic             dir_prev;
    logic [CNT_W-1:0] step_cnt;

    logic                    event_c;
    logic                    dig_active_c;
    logic                    dig_neg_c;
    logic                    dig_restart_c;
    logic                    dig_fire_c;
    logic [8:0]              mag_c;
    logic [8:0]              mag_sh_c;
    logic signed [SUM_W-1:0] mag_ext_c;
    logic signed [SUM_W-1:0] analog_c;
    logic signed [SUM_W-1:0] digital_c;
    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] total_c;
    logic [CNT_W-1:0]        cnt_next_c;

    // Step computation from the registered input copies.
    always_comb begin
        event_c       = primed && (spin_q[8] != tog_prev);
        // Magnitude is 9 bits wide so that -128 becomes 128 rather than overflowing.
        mag_c         = spin_q[7] ? (~{1'b1, spin_q[7:0]}) + 9'd1 : {1'b0, spin_q[7:0]};
        mag_sh_c      = mag_c >> SCALE_SHIFT;
        mag_ext_c     = {1'b0, mag_sh_c};
        analog_c      = '0;
        if (event_c) begin
            analog_c = spin_q[7] ? -mag_ext_c : mag_ext_c;
        end

        dig_active_c  = dl_q ^ dr_q;
        dig_neg_c     = dl_q;
        dig_restart_c = (step_cnt == '0) || (dig_neg_c != dir_prev);
        dig_fire_c    = enable && dig_active_c &&
                        (dig_restart_c || (step_cnt == CNT_W'(STEP_DIV)));
        digital_c     = '0;
        if (dig_fire_c) begin
            digital_c = dig_neg_c ? -SUM_W'(DIG_STEP) : SUM_W'(DIG_STEP);
        end

        if (!enable || !dig_active_c) begin
            cnt_next_c = '0;
        end else if (dig_fire_c) begin
            cnt_next_c = CNT_W'(1);
        end else begin
            cnt_next_c = step_cnt + CNT_W'(1);
        end

        sum_c   = analog_c + digital_c;
        total_c = invert ? -sum_c : sum_c;
    end

    // Input stage, toggle tracking, step timer and position accumulator.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            spin_q    <= '0;
            dl_q      <= 1'b0;
            dr_q      <= 1'b0;
            tog_prev  <= 1'b0;
            primed    <= 1'b0;
            dir_prev  <= 1'b0;
            step_cnt  <= '0;
            position  <= '0;
            moved     <= 1'b0;
            direction <= 1'b0;
        end else begin
            spin_q <= spinner_in;
            dl_q   <= dig_left;
            dr_q   <= dig_right;

            // Toggle tracking runs even while disabled so stale events are dropped.
            if (!primed) begin
                tog_prev <= spin_q[8];
                primed   <= 1'b1;
            end else if (event_c) begin
                tog_prev <= spin_q[8];
            end

            step_cnt <= cnt_next_c;
            if (dig_active_c) begin
                dir_prev <= dig_neg_c;
            end

            moved <= 1'b0;
            if (enable && (total_c != '0)) begin
                position  <= position + total_c[7:0];
                moved     <= 1'b1;
                direction <= total_c[SUM_W-1];
            end
        end
    end

endmodule

// File: tb/tb_spinner_accum.sv
// Bench for spinner_accum: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the position accumulator.
module tb_spinner_accum;

    localparam int STEP_DIV    = 4;
    localparam int DIG_STEP    = 2;
    localparam int SCALE_SHIFT = 1;

    logic       clk_sys    = 1'b0;
    logic       reset_n    = 1'b0;
    logic [8:0] spinner_in = 9'h100;
    logic       dig_left   = 1'b0;
    logic       dig_right  = 1'b0;
    logic       enable     = 1'b1;
    logic       invert     = 1'b0;
    logic [7:0] position;
    logic       moved;
    logic       direction;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    spinner_accum #(
        .STEP_DIV   (STEP_DIV),
        .DIG_STEP   (DIG_STEP),
        .SCALE_SHIFT(SCALE_SHIFT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .spinner_in(spinner_in),
        .dig_left  (dig_left),
        .dig_right (dig_right),
        .enable    (enable),
        .invert    (invert),
        .position  (position),
        .moved     (moved),
        .direction (direction)
    );

    // Reference model: one-cycle input sample, then signed integer arithmetic.
    logic [8:0] mq_spin   = '0;
    logic       mq_dl     = 1'b0;
    logic       mq_dr     = 1'b0;
    logic       m_tog     = 1'b0;
    logic       m_primed  = 1'b0;
    logic       m_rundir  = 1'b0;
    int         m_run     = 0;
    int         m_pos     = 0;
    logic       m_moved   = 1'b0;
    logic       m_dir     = 1'b0;
    logic       m_event;
    logic       m_active;
    int         m_k;
    int         m_a;
    int         m_ds;
    int         m_tot;

    function automatic int scaled(input logic [7:0] v);
        int d;
        int mag;
        d = int'(v);
        if (d > 127) d = d - 256;
        mag = (d < 0) ? -d : d;
        mag = mag / (1 << SCALE_SHIFT);
        return (d < 0) ? -mag : mag;
    endfunction

    always_comb begin
        m_event  = m_primed && (mq_spin[8] != m_tog);
        m_active = mq_dl ^ mq_dr;
        m_k      = (m_run == 0 || mq_dl != m_rundir) ? 0 : m_run;
        m_a      = m_event ? scaled(mq_spin[7:0]) : 0;
        m_ds     = 0;
        if (enable && m_active && (m_k % STEP_DIV == 0)) m_ds = mq_dl ? -DIG_STEP : DIG_STEP;
        m_tot    = invert ? -(m_a + m_ds) : (m_a + m_ds);
    end

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            mq_spin  <= '0;
            mq_dl    <= 1'b0;
            mq_dr    <= 1'b0;
            m_tog    <= 1'b0;
            m_primed <= 1'b0;
            m_rundir <= 1'b0;
            m_run    <= 0;
            m_pos    <= 0;
            m_moved  <= 1'b0;
            m_dir    <= 1'b0;
        end else begin
            mq_spin <= spinner_in;
            mq_dl   <= dig_left;
            mq_dr   <= dig_right;
            if (!m_primed) begin
                m_tog    <= mq_spin[8];
                m_primed <= 1'b1;
            end else if (m_event) begin
                m_tog <= mq_spin[8];
            end
            if (!enable || !m_active) begin
                m_run <= 0;
            end else begin
                m_run    <= m_k + 1;
                m_rundir <= mq_dl;
            end
            if (enable && m_tot != 0) begin
                m_pos   <= (m_pos + m_tot + 512) % 256;
                m_moved <= 1'b1;
                m_dir   <= (m_tot < 0);
            end else begin
                m_moved <= 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic spin(input logic [7:0] d);
        spinner_in = {~spinner_in[8], d};
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        spinner_in = 9'h100;
        dig_left   = 1'b0;
        dig_right  = 1'b0;
        enable     = 1'b1;
        invert     = 1'b0;
        cyc(3);
        checks++;
        if (position !== 8'd0) begin errors++; $display("FAIL reset_position: got %0d expected 0", position); end
        checks++;
        if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved: got %0b expected 0", moved); end
        checks++;
        if (direction !== 1'b0) begin errors++; $display("FAIL reset_direction: got %0b expected 0", direction); end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            checks++;
            if (moved !== 1'b0 || position !== 8'd0) begin
                errors++;
                $display("FAIL prime_no_event: got pos %0d moved %0b expected pos 0 moved 0", position, moved);
            end
        end
    endtask

    task automatic test_analog();
        spin(8'h0A);
        cyc(1);
        checks++;
        if (moved !== 1'b0 || position !== 8'd0) begin
            errors++;
            $display("FAIL analog_latency: got pos %0d moved %0b expected pos 0 moved 0", position, moved);
        end
        cyc(1);
        checks++;
        if (moved !== 1'b1 || position !== 8'd5) begin
            errors++;
            $display("FAIL analog_pos: got pos %0d moved %0b expected pos 5 moved 1", position, moved);
        end
        cyc(1);
        checks++;
        if (moved !== 1'b0) begin errors++; $display("FAIL analog_pulse_width: got %0b expected 0", moved); end
        spin(8'hFA);
        cyc(2);
        checks++;
        if (position !== 8'd2 || direction !== 1'b1) begin
            errors++;
            $display("FAIL analog_neg: got pos %0d dir %0b expected pos 2 dir 1", position, direction);
        end
        spinner_in = {spinner_in[8], 8'hFA};
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++;
            if (moved !== 1'b0 || position !== 8'd2) begin
                errors++;
                $display("FAIL analog_no_toggle: got pos %0d moved %0b expected pos 2 moved 0", position, moved);
            end
        end
        spin(8'h80);
        cyc(2);
        checks++;
        if (position !== 8'd194) begin errors++; $display("FAIL analog_min_delta: got %0d expected 194", position); end
        cyc(1);
    endtask

    task automatic test_digital();
        int p0;
        int pulses;
        p0     = m_pos;
        pulses = 0;
        dig_right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (moved === 1'b1) pulses++;
        end
        dig_right = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (moved === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL digital_step_count: got %0d expected 3", pulses); end
        checks++;
        if (position !== 8'(p0 + 6)) begin
            errors++;
            $display("FAIL digital_hold_pos: got %0d expected %0d", position, 8'(p0 + 6));
        end
        dig_left  = 1'b1;
        dig_right = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (moved === 1'b1) pulses++;
        end
        dig_left  = 1'b0;
        dig_right = 1'b0;
        cyc(2);
        checks++;
        if (pulses != 0 || position !== 8'(p0 + 6)) begin
            errors++;
            $display("FAIL digital_both: got pulses %0d pos %0d expected pulses 0 pos %0d", pulses, position, 8'(p0 + 6));
        end
        pulses   = 0;
        dig_left = 1'b1;
        cyc(3);
        dig_left  = 1'b0;
        dig_right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (moved === 1'b1) pulses++;
            if (i == 2) dig_right = 1'b0;
        end
        cyc(2);
        checks++;
        if (position !== 8'(p0 + 6) || direction !== 1'b0) begin
            errors++;
            $display("FAIL digital_reverse: got pos %0d dir %0b expected pos %0d dir 0", position, direction, 8'(p0 + 6));
        end
    endtask

    task automatic test_combined();
        int p0;
        int pulses;
        p0     = m_pos;
        pulses = 0;
        spin(8'h06);
        dig_left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (i == 0) dig_left = 1'b0;
            if (moved === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || position !== 8'(p0 + 1)) begin
            errors++;
            $display("FAIL combined_sum: got pulses %0d pos %0d expected pulses 1 pos %0d", pulses, position, 8'(p0 + 1));
        end
        pulses = 0;
        spin(8'h04);
        dig_left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (i == 0) dig_left = 1'b0;
            if (moved === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || position !== 8'(p0 + 1)) begin
            errors++;
            $display("FAIL combined_cancel: got pulses %0d pos %0d expected pulses 0 pos %0d", pulses, position, 8'(p0 + 1));
        end
    endtask

    task automatic test_invert();
        spinner_in = {spinner_in[8], 8'h00};
        reset_n    = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        invert  = 1'b1;
        cyc(3);
        spin(8'h07);
        cyc(2);
        checks++;
        if (position !== 8'd253 || direction !== 1'b1 || moved !== 1'b1) begin
            errors++;
            $display("FAIL invert_scale: got pos %0d dir %0b moved %0b expected pos 253 dir 1 moved 1", position, direction, moved);
        end
        spin(8'hFF);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++;
            if (moved !== 1'b0 || position !== 8'd253) begin
                errors++;
                $display("FAIL invert_small: got pos %0d moved %0b expected pos 253 moved 0", position, moved);
            end
        end
        invert = 1'b0;
    endtask

    task automatic test_enable();
        int p0;
        p0     = m_pos;
        enable = 1'b0;
        for (int t = 0; t < 3; t++) begin
            spin(8'(20 + t * 10));
            for (int i = 0; i < 2; i++) begin
                cyc(1);
                checks++;
                if (moved !== 1'b0) begin errors++; $display("FAIL enable_off_moved: got %0b expected 0", moved); end
            end
        end
        enable = 1'b1;
        cyc(2);
        checks++;
        if (position !== 8'(p0)) begin errors++; $display("FAIL enable_frozen: got %0d expected %0d", position, 8'(p0)); end
        spin(8'h0A);
        cyc(2);
        checks++;
        if (position !== 8'(p0 + 5)) begin
            errors++;
            $display("FAIL enable_resume: got %0d expected %0d", position, 8'(p0 + 5));
        end
        dig_right = 1'b1;
        cyc(5);
        reset_n = 1'b0;
        cyc(1);
        checks++;
        if (position !== 8'd0 || moved !== 1'b0 || direction !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got pos %0d moved %0b dir %0b expected 0 0 0", position, moved, direction);
        end
        dig_right  = 1'b0;
        spinner_in = {spinner_in[8], 8'h00};
        reset_n    = 1'b1;
        cyc(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cyc(1);
            checks++;
            if (position !== 8'(m_pos) || moved !== m_moved || direction !== m_dir) begin
                errors++;
                $display("FAIL random_cycle%0d: got pos %0d moved %0b dir %0b expected pos %0d moved %0b dir %0b",
                         i, position, moved, direction, m_pos, m_moved, m_dir);
            end
            if ($urandom_range(0, 2) == 0) spin(8'($urandom_range(0, 255)));
            else if ($urandom_range(0, 4) == 0) spinner_in = {spinner_in[8], 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 7) == 0) begin
                dig_left  = 1'($urandom_range(0, 1));
                dig_right = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) invert = ~invert;
            reset_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_analog();
        test_digital();
        test_combined();
        test_invert();
        test_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
